// File: rtl/ex4_run_ctrl_pkg.sv
// ex4_pkg: shared types and constants for the ex4 run controller.
package ex4_pkg;

    typedef enum logic [2:0] {IDLE, INIT, RUN, HIT, TOUT} ex4_state_e;

    localparam int EX4_SW          = 32;
    localparam int EX4_TIMEOUT_DEF = 1000000;

    // x^33 + x^20 + 1 in right-shifting Galois form (maximal length for 33 bits)
    localparam logic [EX4_SW:0] EX4_LFSR_TAPS = 33'h1_0008_0000;

endpackage

// File: rtl/ex4_run_ctrl_if.sv
// ex4_run_ctrl_if: requester stimulus bus (requests + vectors in, grant + stimulus out).
interface ex4_run_ctrl_if
    import ex4_pkg::*;
#(
    parameter int SW   = EX4_SW,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        req;
    logic [NREQ*(SW+1)-1:0] vec_in;   // slice i = {X, C[SW-1:0]}
    logic [NREQ-1:0]        gnt;
    logic                   X_out;
    logic [SW-1:0]          C_out;

    modport master (output req, vec_in, input gnt, X_out, C_out);
    modport slave  (input req, vec_in, output gnt, X_out, C_out);
endinterface

// File: rtl/ex4_run_ctrl_rr_arb.sv
// ex4_rr_arb: round-robin winner select; search starts one past the last winner.
module ex4_rr_arb #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            CLK,
    input  logic            Clear,
    input  logic [NREQ-1:0] req,
    input  logic            upd,      // commit the current winner as the new pointer
    output logic [NREQ-1:0] gnt_oh,
    output logic            any,
    output logic [PW-1:0]   win_idx
);
    logic [PW-1:0] ptr;

    // first asserted request after ptr, wrapping modulo NREQ
    always_comb begin
        gnt_oh  = '0;
        any     = 1'b0;
        win_idx = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any     = 1'b1;
                win_idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
        if (any) gnt_oh[win_idx] = 1'b1;
    end

    // pointer parks at NREQ-1 so requester 0 goes first after reset
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear)    ptr <= PW'(NREQ - 1);
        else if (upd) ptr <= win_idx;
    end
endmodule

// File: rtl/ex4_run_ctrl.sv
// ex4_run_ctrl: run sequencer (clear -> stimulate -> watch target) with
// round-robin sharing of the machine's X/C stimulus among requesters.
// Optional: EX4_RUN_CTRL_LFSR_EN adds an LFSR that fills idle RUN cycles.
module ex4_run_ctrl
    import ex4_pkg::*;
#(
    parameter int SW      = EX4_SW,
    parameter int NREQ    = 4,
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = EX4_TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             start,
    input  logic [SW-1:0]    target,
    input  logic [SW-1:0]    state,
    ex4_run_ctrl_if.slave    bus,
    output logic             dut_clear,
    output logic             busy,
    output logic             hit,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    ex4_state_e      st, st_nxt;
    logic            match, tmo_hit, run_go;
    logic [NREQ-1:0] win_oh;
    logic            win_any;
    logic [PW-1:0]   win_idx;
    logic [SW:0]     win_vec, idle_vec;

    assign match   = (state == target);
    assign tmo_hit = (cycles == CNT_W'(TIMEOUT - 1));
    // stays in RUN this cycle: the only time grants/stimulus are produced
    assign run_go  = (st == RUN) && (st_nxt == RUN);
    assign win_vec = bus.vec_in[int'(win_idx)*(SW+1) +: SW+1];

    ex4_rr_arb #(.NREQ(NREQ)) u_arb (
        .CLK     (CLK),
        .Clear   (Clear),
        .req     (bus.req),
        .upd     (run_go && win_any),
        .gnt_oh  (win_oh),
        .any     (win_any),
        .win_idx (win_idx)
    );

`ifdef EX4_RUN_CTRL_LFSR_EN
    logic [SW:0] lfsr;

    // free-running in RUN; seeded only by reset
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear)          lfsr <= (SW+1)'(1);
        else if (st == RUN) lfsr <= lfsr[0] ? ((lfsr >> 1) ^ (SW+1)'(EX4_LFSR_TAPS)) : (lfsr >> 1);
    end

    assign idle_vec = lfsr;
`else
    assign idle_vec = '0;
`endif

    // FSM state register
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) st <= IDLE;
        else       st <= st_nxt;
    end

    // next state and status decode; match beats timeout
    always_comb begin
        st_nxt    = st;
        dut_clear = 1'b0;
        busy      = 1'b0;
        hit       = 1'b0;
        timeout   = 1'b0;
        case (st)
            IDLE: if (start) st_nxt = INIT;
            INIT: begin
                dut_clear = 1'b1;
                busy      = 1'b1;
                st_nxt    = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (match)        st_nxt = HIT;
                else if (tmo_hit) st_nxt = TOUT;
            end
            HIT: begin
                hit = 1'b1;
                if (start) st_nxt = INIT;
            end
            TOUT: begin
                timeout = 1'b1;
                if (start) st_nxt = INIT;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // cycle counter: zeroed on entry to INIT, counts RUN cycles, frozen at run end
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear)                         cycles <= '0;
        else if (st_nxt == INIT)           cycles <= '0;
        else if (run_go && cycles != '1)   cycles <= cycles + 1'b1;
    end

    // registered grant and stimulus; zero outside of an ongoing RUN
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            bus.gnt                 <= '0;
            {bus.X_out, bus.C_out}  <= '0;
        end else if (run_go && win_any) begin
            bus.gnt                 <= win_oh;
            {bus.X_out, bus.C_out}  <= win_vec;
        end else if (run_go) begin
            bus.gnt                 <= '0;
            {bus.X_out, bus.C_out}  <= idle_vec;
        end else begin
            bus.gnt                 <= '0;
            {bus.X_out, bus.C_out}  <= '0;
        end
    end
endmodule

// File: tb/tb_ex4_run_ctrl.sv
// tb_ex4_run_ctrl: directed checks plus a grant/stimulus scoreboard.
module tb_ex4_run_ctrl;
    localparam int SW = 32, NREQ = 4, CNT_W = 20, TMO = 64;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [SW:0]     vec;
    } exp_t;

    logic             CLK = 1'b0, Clear = 1'b1, start = 1'b0;
    logic [SW-1:0]    target = '0, state = '0;
    logic             dut_clear, busy, hit, timeout;
    logic [CNT_W-1:0] cycles;

    int   n_tests = 0, n_fail = 0;
    exp_t sb[$];

    ex4_run_ctrl_if #(.SW(SW), .NREQ(NREQ)) bus ();

    ex4_run_ctrl #(.SW(SW), .NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .Clear     (Clear),
        .start     (start),
        .target    (target),
        .state     (state),
        .bus       (bus),
        .dut_clear (dut_clear),
        .busy      (busy),
        .hit       (hit),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [SW:0] lfsr_step(input logic [SW:0] v);
        logic [SW:0] taps;
        taps = 33'h1_0008_0000;
        return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
    endfunction

    // start pulse from IDLE/HIT/TOUT; ends on RUN cycle 0
    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_clr1"}, 64'(dut_clear), 64'd1);
        chk({tag, "_hit0"}, 64'(hit), 64'd0);
        chk({tag, "_tmo0"}, 64'(timeout), 64'd0);
        chk({tag, "_cyc0"}, 64'(cycles), 64'd0);
        tick();
        chk({tag, "_clr0"}, 64'(dut_clear), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_cyc_run0"}, 64'(cycles), 64'd0);
    endtask

    // drive req + fresh vectors, push expectation, compare one cycle later
    task automatic sb_step(input string tag, input logic [NREQ-1:0] r,
                           input logic [NREQ-1:0] eg, input logic [SW:0] idle);
        exp_t        e;
        logic [63:0] rnd;
        for (int i = 0; i < NREQ; i++) begin
            rnd = {$urandom(), $urandom()};
            bus.vec_in[i*(SW+1) +: SW+1] = rnd[SW:0];
        end
        bus.req = r;
        e.gnt   = eg;
        e.vec   = idle;
        for (int i = 0; i < NREQ; i++)
            if (eg[i]) e.vec = bus.vec_in[i*(SW+1) +: SW+1];
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(e.gnt));
        chk({tag, "_vec"}, 64'({bus.X_out, bus.C_out}), 64'(e.vec));
    endtask

    task automatic end_by_match(input string tag);
        bus.req = '0;
        state   = target;
        tick();
        state   = '0;
        chk({tag, "_hit"}, 64'(hit), 64'd1);
    endtask

    initial begin
        logic [NREQ-1:0] rr_a [5];
        logic [NREQ-1:0] rr_b [3];
        logic [SW:0]     lf;
        rr_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_b = '{4'b0010, 4'b1000, 4'b0010};

        bus.req    = '0;
        bus.vec_in = '0;
        target     = 32'h0000_0080;
        repeat (2) tick();
        chk("rst_gnt",  64'(bus.gnt), 64'd0);
        chk("rst_xc",   64'({bus.X_out, bus.C_out}), 64'd0);
        chk("rst_clr",  64'(dut_clear), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'({hit, timeout}), 64'd0);
        chk("rst_cyc",  64'(cycles), 64'd0);
        Clear = 1'b0;
        tick();

        // reset mid-run at cycles=57
        do_start("t1");
        bus.req = 4'b0100;
        repeat (57) tick();
        chk("t1_cyc57", 64'(cycles), 64'd57);
        chk("t1_gnt",   64'(bus.gnt), 64'b0100);
        #2 Clear = 1'b1;
        #1;
        chk("t1_async_busy", 64'(busy), 64'd0);
        chk("t1_async_gnt",  64'(bus.gnt), 64'd0);
        chk("t1_async_cyc",  64'(cycles), 64'd0);
        chk("t1_async_rest", 64'({dut_clear, hit, timeout}), 64'd0);
        #1 Clear = 1'b0;
        bus.req = '0;
        tick();
        chk("t1_idle", 64'({busy, dut_clear, hit, timeout}), 64'd0);
        tick();
        chk("t1_idle2", 64'(busy), 64'd0);

        // round-robin, pointer fresh from reset
        do_start("t4");
        for (int k = 0; k < 5; k++) sb_step($sformatf("rr_a%0d", k), 4'b1111, rr_a[k], '0);
        for (int k = 0; k < 3; k++) sb_step($sformatf("rr_b%0d", k), 4'b1010, rr_b[k], '0);
`ifndef EX4_RUN_CTRL_LFSR_EN
        sb_step("rr_none", 4'b0000, 4'b0000, '0);
`endif
        end_by_match("t4");

        // start from HIT, near-miss pattern, hit on RUN cycle 10
        do_start("t2");
        repeat (5) tick();
        state = 32'h0000_0081;
        tick();
        state = '0;
        chk("t2_nearmiss", 64'(busy), 64'd1);
        repeat (4) tick();
        chk("t2_cyc10", 64'(cycles), 64'd10);
        state = 32'h0000_0080;
        tick();
        state = '0;
        chk("t2_hit",    64'(hit), 64'd1);
        chk("t2_cyc",    64'(cycles), 64'd10);
        chk("t2_busy",   64'(busy), 64'd0);
        chk("t2_gnt",    64'(bus.gnt), 64'd0);
        chk("t2_tmo",    64'(timeout), 64'd0);
        tick();
        chk("t2_frozen", 64'({hit, cycles}), {1'b1, 20'd10});

        // start ignored during RUN, then timeout
        do_start("t5");
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_cyc4", 64'(cycles), 64'd4);
        chk("t5_noclr", 64'({dut_clear, busy}), 64'b01);
        tick();
        chk("t5_cyc5", 64'(cycles), 64'd5);
        repeat (TMO - 1 - 5) tick();
        chk("t3_last",  64'({busy, timeout}), 64'b10);
        chk("t3_cycl",  64'(cycles), 64'(TMO - 1));
        tick();
        chk("t3_tmo",   64'(timeout), 64'd1);
        chk("t3_hit0",  64'(hit), 64'd0);
        chk("t3_cyc",   64'(cycles), 64'(TMO - 1));
        chk("t3_busy0", 64'(busy), 64'd0);

        // match on the last cycle beats timeout
        do_start("t3b");
        repeat (TMO - 1) tick();
        state = target;
        tick();
        state = '0;
        chk("t3b_hit", 64'({hit, timeout}), 64'b10);
        chk("t3b_cyc", 64'(cycles), 64'(TMO - 1));

        // idle RUN stimulus after a fresh reset: LFSR from seed 1, or zeros
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        tick();
        do_start("t6");
        lf = 33'd1;
        for (int k = 0; k < 6; k++) begin
`ifdef EX4_RUN_CTRL_LFSR_EN
            sb_step($sformatf("idle%0d", k), 4'b0000, 4'b0000, lf);
            lf = lfsr_step(lf);
`else
            sb_step($sformatf("idle%0d", k), 4'b0000, 4'b0000, '0);
`endif
        end
        end_by_match("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex4_run_ctrl.md
Name: ex4_run_ctrl

Overview:
Run controller for the 32-bit ex4 state machine datapath.
- Shares the machine's stimulus inputs (X plus the C vector) among NREQ requesters through round-robin arbitration.
- Sequences each run as clear, then stimulate, then watch for a target state.
- Ends the run on target match or on timeout, and reports the cycle count.

Parameters:
SW, 32, state/C-vector width of the controlled machine
NREQ, 4, number of stimulus requesters
CNT_W, 20, cycle counter width
TIMEOUT, 1000000, RUN cycles before a run is abandoned; must be < 2**CNT_W

Ports:
CLK  input  1  clock, rising edge
Clear  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse that begins a run
target  input  SW  state value that ends a run successfully
state  input  SW  current state vector of the controlled machine {S31..S0}
req  input  NREQ  per-requester stimulus request
vec_in  input  NREQ*(SW+1)  requester i owns slice [i*(SW+1) +: SW+1], packed as {X, C[SW-1:0]}
gnt  output  NREQ  one-hot grant, registered
X_out  output  1  stimulus X to the machine
C_out  output  SW  stimulus C vector to the machine
dut_clear  output  1  synchronous clear to the machine
busy  output  1  run in progress (INIT or RUN)
hit  output  1  sticky: last run reached target
timeout  output  1  sticky: last run timed out
cycles  output  CNT_W  RUN cycles elapsed; frozen when the run ends

Behaviour:
Reset (Clear=1, asynchronous):
- All outputs go to 0 (gnt, X_out, C_out, dut_clear, busy, hit, timeout, cycles).
- FSM goes to IDLE; round-robin pointer goes to NREQ-1, so requester 0 has first priority.

FSM states and transitions:
- IDLE: start=1 → INIT. hit, timeout and cycles are cleared on entry to INIT.
- INIT: exactly one cycle. dut_clear=1, busy=1, gnt=0, X_out/C_out=0. → RUN.
- RUN:
  - busy=1 and cycles increments by 1 every cycle.
  - state==target is sampled each cycle → HIT.
  - Otherwise, cycles==TIMEOUT-1 → TOUT.
  - If match and timeout occur in the same cycle, the match wins.
- HIT: hit=1, busy=0, gnt=0, X_out/C_out=0. start → INIT.
- TOUT: timeout=1, otherwise identical to HIT.

Start handling:
- start is ignored while in INIT or RUN.
- start in HIT/TOUT begins a new run, and hit/timeout drop in the same cycle INIT is entered.

Arbitration (RUN only):
- Search order begins at pointer+1 and wraps modulo NREQ; the first asserted req wins.
- Grant is registered: gnt and {X_out, C_out} = vec_in[winner] update together one cycle after req is sampled.
- The pointer moves to the winner.
- Each grant lasts one cycle; a requester holding req high is re-arbitrated every cycle.
- With no req: gnt=0, X_out=0, C_out=0, and the pointer is unchanged.

Counter rules:
- cycles saturates at 2**CNT_W-1; this is unreachable with a legal TIMEOUT.
- Match detection is a full SW-bit equality; there are no don't-care bits.

Reset mid-run:
- Clear aborts immediately to reset values.
- dut_clear drops; no HIT/TOUT is reported.

Optional Feature:
Macro EX4_RUN_CTRL_LFSR_EN.
- Defined:
  - An internal (SW+1)-bit maximal-length Galois LFSR acts as an implicit lowest-priority requester.
  - Seed 1 on reset; the LFSR advances every RUN cycle.
  - When no req is asserted in RUN, {X_out, C_out} = LFSR value and gnt=0.
- Undefined: no LFSR exists; idle RUN cycles drive zeros.

Decomposition:
- Package ex4_pkg holds:
  - FSM enum {IDLE, INIT, RUN, HIT, TOUT}
  - constants EX4_SW=32 and EX4_TIMEOUT_DEF=1000000
  - LFSR tap constant
- Sub-module ex4_rr_arb (parameter NREQ): combinational round-robin winner select from req and pointer, with a registered pointer update. The top module owns the FSM, counter and output registers.

Test Plan:
1. Reset: Clear=1 mid-RUN at cycles=57 → all outputs 0 asynchronously. After release, IDLE; no hit/timeout.
2. Run to target: target=32'h00000080, state driven to 0x80 on RUN cycle 10 → hit=1 next cycle, cycles=10 frozen, busy=0, gnt=0.
3. Timeout: TIMEOUT=16, state never matches → timeout=1 after 16 RUN cycles, cycles=15, hit=0. Same test with a match on cycle 15 → hit=1, timeout=0.
4. Round-robin: req=4'b1111 constant → gnt sequence 0001, 0010, 0100, 1000, 0001. Then req=4'b1010 → 0010, 1000, 0010. X_out/C_out track the granted slice with 1-cycle latency.
5. Start handling: start pulsed during RUN → ignored, cycles unaffected. Start in HIT → dut_clear high exactly one cycle, hit drops, cycles restarts at 0.
6. LFSR (EX4_RUN_CTRL_LFSR_EN defined): req=0 in RUN → C_out/X_out follow the LFSR sequence from seed 1, gnt=0. Macro undefined → zeros.
